ps2_host_rx: RTL

- Core-side PS/2 receiver that decodes the keyboard/mouse serial streams produced by the ARM-to-FPGA IO block's PS/2 emulation into bytes.
- Synchronises and filters ps2_clk/ps2_data, frames 11-bit packets, checks odd parity, and buffers good bytes in a small FIFO for the core's keyboard/mouse logic.
- One instance per PS/2 channel (keyboard, mouse).

---
 rtl/ps2_host_rx.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: core-side PS/2 receiver. Synchronises and filters the PS/2
// clock/data pair, frames 11-bit packets (start, 8 data LSB-first, odd
// parity, stop), and queues good bytes in a small FIFO.
//
// Ports:
//   clk_sys     system clock, posedge
//   reset_n     async active-low reset
//   ps2_clk     PS/2 clock (async, idles high)
//   ps2_data    PS/2 data (async)
//   rx_data     byte at FIFO head, valid while rx_valid
//   rx_valid    FIFO non-empty
//   rx_rd       pop request, ignored when rx_valid=0
//   parity_err  1-cycle strobe: frame dropped on parity error
//   frame_err   1-cycle strobe: bad start/stop bit or timeout
//   overflow    1-cycle strobe: good byte dropped, FIFO full
//
// Optional (macro PS2RX_SCANCODE_DECODE_EN): scancode decoder on popped
// bytes, adding key_code, key_ext, key_release, key_strobe.
module ps2_host_rx #(
    parameter int unsigned FILTER    = 3,
    parameter int unsigned TIMEOUT   = 4095,
    parameter int unsigned FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_rd,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
`ifdef PS2RX_SCANCODE_DECODE_EN
    ,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_strobe
`endif
);

    localparam int unsigned FCNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned PTR_W  = FIFO_BITS + 1;
    localparam int unsigned DEPTH  = 1 << FIFO_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Input conditioning
    logic              clk_s1, clk_s2, data_s1, data_s2;
    logic              clk_filt;
    logic [FCNT_W-1:0] filt_cnt;
    logic              fall_c;

    // Framing
    state_t            state, state_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic              parity, parity_nxt;
    logic              pbit, pbit_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic              push_c, perr_nxt, ferr_nxt;

    // FIFO
    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr, wptr_nxt, rptr_nxt;
    logic              full_c, empty_c, do_push_c, do_pop_c;
    logic [7:0]        rx_data_nxt;

    // 2-FF synchronisers and clock filter; level changes after FILTER
    // consecutive samples that disagree with it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCNT_W'(FILTER - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= FCNT_W'(filt_cnt + 1'b1);
            end
        end
    end

    // Single-cycle pulse in the cycle the filtered clock drops.
    assign fall_c = clk_filt & ~clk_s2 & (filt_cnt == FCNT_W'(FILTER - 1));

    // Frame FSM state and datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            pbit       <= 1'b0;
            wd         <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            parity     <= parity_nxt;
            pbit       <= pbit_nxt;
            wd         <= wd_nxt;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
        end
    end

    // Frame FSM next-state; watchdog only runs inside a frame.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        parity_nxt  = parity;
        pbit_nxt    = pbit;
        wd_nxt      = wd;
        push_c      = 1'b0;
        perr_nxt    = 1'b0;
        ferr_nxt    = 1'b0;

        if (state == ST_IDLE || fall_c) begin
            wd_nxt = '0;
        end else if (wd == WD_W'(TIMEOUT)) begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
            wd_nxt    = '0;
        end else begin
            wd_nxt = WD_W'(wd + 1'b1);
        end

        if (fall_c) begin
            case (state)
                ST_IDLE: begin
                    // A high "start" bit is line noise, silently ignored.
                    if (!data_s2) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = '0;
                        parity_nxt  = 1'b0;
                    end
                end
                ST_DATA: begin
                    shreg_nxt   = {data_s2, shreg[7:1]};
                    parity_nxt  = parity ^ data_s2;
                    bit_cnt_nxt = 3'(bit_cnt + 3'd1);
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    pbit_nxt  = data_s2;
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    // Stop-bit error takes precedence over parity error.
                    if (!data_s2) begin
                        ferr_nxt = 1'b1;
                    end else if ((parity ^ pbit) != 1'b1) begin
                        perr_nxt = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FIFO control; full is judged on current pointers so a same-cycle
    // pop never makes room for the incoming byte.
    always_comb begin
        full_c    = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                    (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
        empty_c   = (wptr == rptr);
        do_push_c = push_c & ~full_c;
        do_pop_c  = rx_rd & ~empty_c;
        wptr_nxt  = PTR_W'(wptr + PTR_W'(do_push_c));
        rptr_nxt  = PTR_W'(rptr + PTR_W'(do_pop_c));
        // Bypass when the new head is the slot being written this cycle.
        if (wptr_nxt == rptr_nxt) begin
            rx_data_nxt = '0;
        end else if (do_push_c && (wptr == rptr_nxt)) begin
            rx_data_nxt = shreg;
        end else begin
            rx_data_nxt = mem[rptr_nxt[FIFO_BITS-1:0]];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push_c) begin
            mem[wptr[FIFO_BITS-1:0]] <= shreg;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            rx_valid <= (wptr_nxt != rptr_nxt);
            rx_data  <= rx_data_nxt;
            overflow <= push_c & full_c;
        end
    end

`ifdef PS2RX_SCANCODE_DECODE_EN
    // Scancode decoder: E0/F0 prefixes latch flags for the next key byte.
    logic ext_flag, rel_flag;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_flag    <= 1'b0;
            rel_flag    <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_strobe  <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (do_pop_c) begin
                if (rx_data == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_data == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else begin
                    key_code    <= rx_data;
                    key_ext     <= ext_flag;
                    key_release <= rel_flag;
                    key_strobe  <= 1'b1;
                    ext_flag    <= 1'b0;
                    rel_flag    <= 1'b0;
                end
            end
        end
    end
`endif

endmodule
